shumezuesi_16bit: RTL
=====================

# shumezuesi_16bit

Multi-cycle 16x16 shift-add multiplier in the execute stage of the 16-bit CPU. It captures two 16-bit operands on a start strobe, iterates one partial-product bit per clock, and produces a 32-bit product. The low half feeds the data input of the writeback-select 2:1 16-bit multiplexer; the high half feeds a dedicated high-result register path. It replaces the single-cycle multiply path so that the ALU critical path stays short.

## Interface

Parameters:
- GJERESIA, 16, operand width. The block is verified only at 16; the product is 2*GJERESIA bits.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Fillo  in  1  start strobe; sampled on the rising edge.
- Shenja  in  1  operand mode, captured with Fillo: 1 = two's-complement signed, 0 = unsigned.
- hyrja0  in  16  multiplicand, captured with Fillo.
- hyrja1  in  16  multiplier, captured with Fillo.
- Zene  out  1  busy; high while iterating.
- Gati  out  1  done; a one-cycle pulse when the product is valid.
- dalja_ulet  out  16  product bits [15:0]; drives the writeback mux data input.
- dalja_larte  out  16  product bits [31:16].

## Operation

- States:
  - IDLE: no operation in progress.
  - RUN: iterating.
  - DONE: product just completed.
- IDLE with Fillo=1:
  - Capture operand magnitudes. In signed mode, a negative operand is negated (two's complement); -32768 has magnitude 0x8000, which fits unsigned.
  - Capture the sign flag `neg = Shenja & (hyrja0[15] ^ hyrja1[15])`.
  - Clear the 32-bit accumulator and the 4-bit iteration counter; go to RUN.
- RUN, one iteration per clock:
  - If the multiplier LSB is 1, add the multiplicand magnitude to accumulator[31:16], keeping the carry.
  - Shift {carry, accumulator} right by 1; shift the multiplier right by 1; increment the counter.
  - After the iteration with counter=15, go to DONE.
- DONE:
  - The final product is registered into dalja_larte and dalja_ulet, negated (32-bit two's complement) when neg=1.
  - Gati=1 for exactly this cycle.
  - Next state is IDLE, or RUN if Fillo=1 in this cycle. A back-to-back start is accepted; operands are captured as in IDLE.
- Fillo is ignored while in RUN. Operands and mode do not change mid-operation.
- Operand inputs are don't-care except at the accepting edge.
- Result outputs hold their last value until the next DONE. They do not change during RUN.
- Arithmetic is exact: the full 32-bit product, with no overflow or saturation.
- The counter wraps 15 -> 0 only on the RUN -> DONE transition.

## Timing

- Reset (Resetn=0, asynchronous, immediate): state=IDLE, Zene=0, Gati=0, dalja_ulet=0x0000, dalja_larte=0x0000, accumulator and counter cleared.
- Reset asserted mid-operation aborts the operation. Outputs go to their reset values with no Gati pulse.
- Reset release: the first accepting edge is the first rising edge with Resetn=1.
- Latency, with E0 the edge that samples Fillo=1:
  - Zene=1 from after E0 through after E15.
  - RUN iterations occur on E1..E16.
  - State is DONE after E16; Gati=1 and the outputs are valid in the cycle between E16 and E17.
  - Latency from E0 to valid result is 16 clocks.
- Zene=0 in IDLE and DONE. Gati and Zene are never both 1.
- Throughput: one multiply per 17 clocks with back-to-back starts issued in the DONE cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- Unsigned 3 x 5: hyrja0=0x0003, hyrja1=0x0005, Shenja=0, Fillo pulse at E0. Required: Zene high for 16 cycles, Gati pulse after E16, dalja_larte=0x0000, dalja_ulet=0x000F.
- Unsigned max: 0xFFFF x 0xFFFF, Shenja=0. Required: dalja_larte=0xFFFE, dalja_ulet=0x0001.
- Signed: -1 x -1 (0xFFFF, 0xFFFF, Shenja=1). Required: 0x0000_0001. -32768 x 2 (0x8000, 0x0002). Required: dalja_larte=0xFFFF, dalja_ulet=0x0000.
- Start while busy: second Fillo with 7 x 7 at E5 of a 3 x 5 run. Required: ignored; result 0x0000_000F at E16; exactly one Gati pulse.
- Back-to-back: Fillo with 0x0100 x 0x0100 asserted in the DONE cycle of the 3 x 5 run. Required: Gati again 16 clocks later, result 0x0001_0000; the 3 x 5 result stays visible until then.
- Reset mid-op: Resetn low between E8 and E9 of a 0x1234 x 0x5678 run. Required: immediate Zene=0, Gati=0, outputs 0x0000, no Gati pulse afterwards. A fresh start then yields 0x0626_0060.

Source files
------------

// File: rtl/shumezuesi_16bit.sv
// rtl/shumezuesi_16bit.sv - multi-cycle shift-add 16x16 multiplier, signed/unsigned, 32-bit product
module shumezuesi_16bit #(
  parameter int GJERESIA = 16
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Fillo,
  input  logic                Shenja,
  input  logic [GJERESIA-1:0] hyrja0,
  input  logic [GJERESIA-1:0] hyrja1,
  output logic                Zene,
  output logic                Gati,
  output logic [GJERESIA-1:0] dalja_ulet,
  output logic [GJERESIA-1:0] dalja_larte
);

  localparam int W  = GJERESIA;
  localparam int CW = $clog2(GJERESIA);
  localparam logic [CW-1:0] LAST = CW'(GJERESIA - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    mcand, mplier;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic            accept;
  logic [W-1:0]    mag0, mag1;
  logic [W:0]      sum;
  logic [2*W-1:0]  acc_next, result;

  assign accept = Fillo && (state != RUN);

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  assign mag0 = (Shenja && hyrja0[W-1]) ? -hyrja0 : hyrja0;
  assign mag1 = (Shenja && hyrja1[W-1]) ? -hyrja1 : hyrja1;

  assign sum      = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_next = {sum, acc[W-1:1]};
  assign result   = neg ? -acc_next : acc_next;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = Fillo ? RUN : IDLE;
      RUN:     state_next = (cnt == LAST) ? DONE : RUN;
      DONE:    state_next = Fillo ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Zene = (state == RUN);
    Gati = (state == DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      dalja_ulet  <= '0;
      dalja_larte <= '0;
    end else if (accept) begin
      mcand  <= mag0;
      mplier <= mag1;
      neg    <= Shenja & (hyrja0[W-1] ^ hyrja1[W-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      // The final iteration lands straight in the result registers so they are valid in DONE.
      if (cnt == LAST) {dalja_larte, dalja_ulet} <= result;
    end
  end

endmodule
